// File: rtl/des_key_schedule_ctrl.sv
// DES key schedule sequencer.
// Latches a 64-bit key through PC-1, then hands out the 16 round subkeys
// (C/D rotation followed by PC-2) one per valid/ready transfer, in K1..K16
// order for encryption or K16..K1 for decryption.
// Optional feature: define KEY_PARITY_CHK_EN to reject keys whose bytes do
// not all have odd parity (reported on the sticky PARITY_ERR flag).
module des_key_schedule_ctrl #(
    parameter logic [15:0] SHIFT_SCHED = 16'h7EFC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [63:0] KEY_IN,
    input  logic        START,
    input  logic        DECRYPT,
    input  logic        ABORT,
    output logic [47:0] SUBKEY,
    output logic        SUBKEY_VALID,
    input  logic        SUBKEY_READY,
    output logic [3:0]  ROUND,
    output logic        BUSY,
    output logic        DONE,
    output logic        PARITY_ERR
);

    // FIPS 46-3 tables, 1-based bit positions counted from the MSB
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r = {r[54:0], k[6'(64 - PC1_TAB[i])]};
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r = {r[46:0], cd[6'(56 - PC2_TAB[i])]};
        return r;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  cnt_q, cnt_d, round_q, round_d;
    logic        dir_q, dir_d;
    logic [47:0] subkey_q, subkey_d;
    logic        valid_q, valid_d;
    logic [55:0] key_cd;
    logic        sh;
    logic        start_ok;
    logic        perr_set, perr_clr;

`ifdef KEY_PARITY_CHK_EN
    logic perr_q;
    logic par_ok;

    // Every key byte must carry an odd number of ones
    always_comb begin
        logic [63:0] t;
        par_ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            t = KEY_IN >> (8 * b);
            par_ok = par_ok & (^t[7:0]);
        end
    end

    assign start_ok   = START && !ABORT && par_ok;
    assign perr_set   = (state_q == S_IDLE) && START && !ABORT && !par_ok;
    assign perr_clr   = (state_q == S_IDLE) && start_ok;
    assign PARITY_ERR = perr_q;

    // Sticky parity flag: set by a rejected start, cleared by an accepted one
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)           perr_q <= 1'b0;
        else if (perr_set) perr_q <= 1'b1;
        else if (perr_clr) perr_q <= 1'b0;
    end
`else
    logic unused_par;
    assign unused_par = ^KEY_IN;
    assign start_ok   = START && !ABORT;
    assign perr_set   = 1'b0;
    assign perr_clr   = 1'b0;
    assign PARITY_ERR = 1'b0;
`endif

    assign SUBKEY       = subkey_q;
    assign SUBKEY_VALID = valid_q;
    assign ROUND        = round_q;
    assign BUSY         = (state_q != S_IDLE);
    assign DONE         = (state_q == S_DONE);

    // Next-state logic: load on start, advance one subkey per transfer
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        round_d  = round_q;
        dir_d    = dir_q;
        subkey_d = subkey_q;
        valid_d  = valid_q;
        key_cd   = pc1(KEY_IN);
        sh       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    // Decrypt starts from C16/D16, which equals the PC-1 value
                    if (DECRYPT) begin
                        c_d     = key_cd[55:28];
                        d_d     = key_cd[27:0];
                        round_d = 4'd15;
                    end else begin
                        c_d     = rotl28(key_cd[55:28], SHIFT_SCHED[0]);
                        d_d     = rotl28(key_cd[27:0], SHIFT_SCHED[0]);
                        round_d = 4'd0;
                    end
                    dir_d    = DECRYPT;
                    cnt_d    = 4'd0;
                    subkey_d = pc2({c_d, d_d});
                    valid_d  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ABORT) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (valid_q && SUBKEY_READY) begin
                    if (cnt_q != 4'd15) begin
                        // Decrypt undoes the rotation of the round just issued
                        sh    = dir_q ? SHIFT_SCHED[round_q] : SHIFT_SCHED[cnt_q + 4'd1];
                        cnt_d = cnt_q + 4'd1;
                        if (dir_q) begin
                            c_d     = rotr28(c_q, sh);
                            d_d     = rotr28(d_q, sh);
                            round_d = round_q - 4'd1;
                        end else begin
                            c_d     = rotl28(c_q, sh);
                            d_d     = rotl28(d_q, sh);
                            round_d = cnt_q + 4'd1;
                        end
                        subkey_d = pc2({c_d, d_d});
                    end else begin
                        valid_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            c_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            round_q  <= '0;
            dir_q    <= 1'b0;
            subkey_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            round_q  <= round_d;
            dir_q    <= dir_d;
            subkey_q <= subkey_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// Testbench for des_key_schedule_ctrl: directed FIPS example plus randomized
// keys, stalls, abort and reset, against a table-driven DES key schedule model.
module tb_des_key_schedule_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [63:0] KEY_IN;
    logic        START, DECRYPT, ABORT, SUBKEY_READY;
    logic [47:0] SUBKEY;
    logic        SUBKEY_VALID, BUSY, DONE, PARITY_ERR;
    logic [3:0]  ROUND;

    int checks   = 0;
    int failures = 0;

    logic [47:0] mk [16];

    int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_schedule_ctrl dut (
        .CLK(CLK), .RST(RST), .KEY_IN(KEY_IN), .START(START), .DECRYPT(DECRYPT),
        .ABORT(ABORT), .SUBKEY(SUBKEY), .SUBKEY_VALID(SUBKEY_VALID),
        .SUBKEY_READY(SUBKEY_READY), .ROUND(ROUND), .BUSY(BUSY), .DONE(DONE),
        .PARITY_ERR(PARITY_ERR));

    always #5 CLK = ~CLK;

    function automatic logic fb64(input logic [63:0] k, input int p);
        logic [63:0] t;
        t = k >> (64 - p);
        return t[0];
    endfunction

    function automatic logic fb56(input logic [55:0] k, input int p);
        logic [55:0] t;
        t = k >> (56 - p);
        return t[0];
    endfunction

    // Reference: Kr = PC-2 of C0/D0 rotated left by the cumulative shift count
    function automatic void model_keys(input logic [63:0] key);
        logic [27:0] c0, d0;
        logic [55:0] cc, dd, cd;
        logic [47:0] k48;
        int tot;
        c0 = '0;
        d0 = '0;
        for (int i = 0; i < 28; i++) begin
            c0 = {c0[26:0], fb64(key, PC1[i])};
            d0 = {d0[26:0], fb64(key, PC1[28 + i])};
        end
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += SHIFTS[r];
            cc  = {c0, c0} << tot;
            dd  = {d0, d0} << tot;
            cd  = {cc[55:28], dd[55:28]};
            k48 = '0;
            for (int j = 0; j < 48; j++) k48 = {k48[46:0], fb56(cd, PC2[j])};
            mk[r] = k48;
        end
    endfunction

    function automatic logic [63:0] odd_parity(input logic [63:0] k);
        logic [63:0] r;
        r = k;
        for (int b = 0; b < 8; b++) begin
            r[8*b] = 1'b0;
            r[8*b] = ~(^(r >> (8 * b) & 64'hFF));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Run one schedule; abort_at >= 0 aborts after that many transfers
    task automatic run_sched(input logic [63:0] key, input logic dec, input int rdy_pct,
                             input int abort_at, output logic [47:0] first_sk,
                             output logic [47:0] last_sk, output int cyc);
        int n;
        int er;
        logic rdy;
        model_keys(key);
        KEY_IN = key;
        DECRYPT = dec;
        ABORT = 1'b0;
        START = 1'b1;
        SUBKEY_READY = ($urandom_range(99) < rdy_pct);
        tick;
        START = 1'b0;
        KEY_IN = {$urandom, $urandom};
        DECRYPT = ~dec;
        chk("start_latency_valid", 64'(SUBKEY_VALID), 64'd1);
        first_sk = SUBKEY;
        last_sk = '0;
        n = 0;
        cyc = 0;
        while (n < 16 && cyc < 400) begin
            er = dec ? 15 - n : n;
            chk("subkey", 64'(SUBKEY), 64'(mk[er]));
            chk("round", 64'(ROUND), 64'(er));
            chk("valid_issue", 64'(SUBKEY_VALID), 64'd1);
            chk("busy_issue", 64'(BUSY), 64'd1);
            chk("done_issue", 64'(DONE), 64'd0);
            chk("perr_issue", 64'(PARITY_ERR), 64'd0);
            if (n == abort_at) begin
                ABORT = 1'b1;
                START = 1'b0;
                SUBKEY_READY = 1'($urandom_range(1));
                tick;
                ABORT = 1'b0;
                chk("abort_valid", 64'(SUBKEY_VALID), 64'd0);
                chk("abort_busy", 64'(BUSY), 64'd0);
                chk("abort_done", 64'(DONE), 64'd0);
                tick;
                chk("abort_no_done", 64'(DONE), 64'd0);
                chk("abort_idle_valid", 64'(SUBKEY_VALID), 64'd0);
                return;
            end
            last_sk = SUBKEY;
            rdy = ($urandom_range(99) < rdy_pct);
            SUBKEY_READY = rdy;
            START = 1'($urandom_range(1));
            KEY_IN = {$urandom, $urandom};
            DECRYPT = 1'($urandom_range(1));
            tick;
            cyc++;
            if (rdy) n++;
        end
        START = 1'b0;
        chk("sched_complete", 64'(n), 64'd16);
        chk("done_pulse", 64'(DONE), 64'd1);
        chk("done_valid", 64'(SUBKEY_VALID), 64'd0);
        chk("done_busy", 64'(BUSY), 64'd1);
        tick;
        chk("done_one_cycle", 64'(DONE), 64'd0);
        chk("idle_busy", 64'(BUSY), 64'd0);
        chk("idle_valid", 64'(SUBKEY_VALID), 64'd0);
    endtask

    initial begin
        logic [47:0] f, l;
        int cyc;
        logic [63:0] k;

        RST = 1'b1;
        KEY_IN = '0;
        START = 1'b0;
        DECRYPT = 1'b0;
        ABORT = 1'b0;
        SUBKEY_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_subkey", 64'(SUBKEY), 64'd0);
        chk("rst_valid", 64'(SUBKEY_VALID), 64'd0);
        chk("rst_round", 64'(ROUND), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_perr", 64'(PARITY_ERR), 64'd0);
        RST = 1'b0;
        tick;

        // FIPS example key, encrypt with READY held high
        run_sched(64'h133457799BBCDFF1, 1'b0, 100, -1, f, l, cyc);
        chk("enc_K1", 64'(f), 64'h1B02EFFC7072);
        chk("enc_K16", 64'(l), 64'hCB3D8B0E17F5);
        chk("enc_back_to_back", 64'(cyc), 64'd16);

        // Same key, decrypt order
        run_sched(64'h133457799BBCDFF1, 1'b1, 100, -1, f, l, cyc);
        chk("dec_first", 64'(f), 64'hCB3D8B0E17F5);
        chk("dec_last", 64'(l), 64'h1B02EFFC7072);

        // Random keys with random stalls
        for (int t = 0; t < 4; t++) begin
            k = odd_parity({$urandom, $urandom});
            run_sched(k, 1'(t % 2), 50, -1, f, l, cyc);
        end

        // START together with ABORT in IDLE is not accepted
        KEY_IN = 64'h133457799BBCDFF1;
        START = 1'b1;
        ABORT = 1'b1;
        tick;
        START = 1'b0;
        ABORT = 1'b0;
        chk("start_abort_valid", 64'(SUBKEY_VALID), 64'd0);
        chk("start_abort_busy", 64'(BUSY), 64'd0);

        // Abort after the 5th transfer, then a fresh key
        run_sched(odd_parity({$urandom, $urandom}), 1'b0, 70, 5, f, l, cyc);
        k = odd_parity({$urandom, $urandom});
        run_sched(k, 1'b0, 60, -1, f, l, cyc);
        chk("post_abort_K1", 64'(f), 64'(mk[0]));

        // Asynchronous reset in the middle of a schedule
        KEY_IN = 64'h133457799BBCDFF1;
        DECRYPT = 1'b0;
        START = 1'b1;
        SUBKEY_READY = 1'b1;
        tick;
        START = 1'b0;
        tick;
        tick;
        #3;
        RST = 1'b1;
        #1;
        chk("async_rst_valid", 64'(SUBKEY_VALID), 64'd0);
        chk("async_rst_subkey", 64'(SUBKEY), 64'd0);
        chk("async_rst_round", 64'(ROUND), 64'd0);
        chk("async_rst_busy", 64'(BUSY), 64'd0);
        chk("async_rst_done", 64'(DONE), 64'd0);
        #2;
        RST = 1'b0;
        tick;
        chk("post_rst_done", 64'(DONE), 64'd0);
        run_sched(odd_parity({$urandom, $urandom}), 1'b1, 80, -1, f, l, cyc);

        // Key with one byte of even parity
`ifdef KEY_PARITY_CHK_EN
        KEY_IN = 64'h133457799BBCDFF0;
        DECRYPT = 1'b0;
        START = 1'b1;
        tick;
        START = 1'b0;
        chk("perr_set", 64'(PARITY_ERR), 64'd1);
        chk("perr_no_valid", 64'(SUBKEY_VALID), 64'd0);
        chk("perr_no_busy", 64'(BUSY), 64'd0);
        tick;
        chk("perr_sticky", 64'(PARITY_ERR), 64'd1);
        run_sched(64'h133457799BBCDFF1, 1'b0, 100, -1, f, l, cyc);
        chk("perr_cleared_K1", 64'(f), 64'h1B02EFFC7072);
`else
        run_sched(64'h133457799BBCDFF0, 1'b0, 100, -1, f, l, cyc);
        chk("noparity_K1", 64'(f), 64'(mk[0]));
        chk("noparity_perr", 64'(PARITY_ERR), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
